// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_pkg;

    localparam int WIDTH = 8;
    localparam int ACC_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

endpackage

// File: rtl/booth_paso.sv
// One combinational Booth step: conditional add/subtract of M into A, then
// arithmetic shift right of {A, Q, Q_1}.
module booth_paso #(
    parameter int WIDTH = booth_pkg::WIDTH,
    parameter int ACC_W = booth_pkg::ACC_W
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [ACC_W-1:0] i_m,
    output logic [ACC_W-1:0] o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [ACC_W-1:0] w_suma;

    always_comb begin
        w_suma = i_a;
        case ({i_q[0], i_q1})
            2'b01:   w_suma = i_a + i_m;
            2'b10:   w_suma = i_a - i_m;
            default: w_suma = i_a;
        endcase
    end

    // Old Q_1 falls off the bottom; the accumulator sign bit is replicated.
    assign {o_a, o_q, o_q1} = {w_suma[ACC_W-1], w_suma, i_q};

endmodule

// File: rtl/booth_multiplicador.sv
// Sequential signed Booth multiplier: one step per clock, started by the
// rising edge of pb_salida, result held with sign and magnitude.
module booth_multiplicador #(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic               Clk_100M,
    input  logic               reset,
    input  logic               pb_salida,
    input  logic [WIDTH-1:0]   multiplicador,
    input  logic [WIDTH-1:0]   multiplicando,
    output logic [2*WIDTH-1:0] producto,
    output logic               signo,
    output logic [2*WIDTH-1:0] magnitud,
    output logic               ocupado,
    output logic               listo,
    output logic [1:0]         o_estado_dbg
);
    import booth_pkg::*;

    localparam int AW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    estado_t          r_estado;
    logic             r_pb_prev;
    logic [AW-1:0]    r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [AW-1:0]    r_m;
    logic [CW-1:0]    r_cnt;

    logic               w_arranque;
    logic [AW-1:0]      w_a;
    logic [WIDTH-1:0]   w_q;
    logic               w_q1;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mag;

    assign w_arranque   = pb_salida & ~r_pb_prev;
    assign w_prod       = {w_a[WIDTH-1:0], w_q};
    assign w_mag        = w_prod[2*WIDTH-1] ? (~w_prod + 1'b1) : w_prod;
    assign o_estado_dbg = r_estado;

    booth_paso #(
        .WIDTH(WIDTH),
        .ACC_W(AW)
    ) u_paso (
        .i_a (r_a),
        .i_q (r_q),
        .i_q1(r_q1),
        .i_m (r_m),
        .o_a (w_a),
        .o_q (w_q),
        .o_q1(w_q1)
    );

    // pb_prev resets high so a button held through reset does not start.
    always_ff @(posedge Clk_100M or posedge reset) begin
        if (reset) begin
            r_estado  <= IDLE;
            r_pb_prev <= 1'b1;
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            producto  <= '0;
            signo     <= 1'b0;
            magnitud  <= '0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
        end else begin
            r_pb_prev <= pb_salida;
            case (r_estado)
                IDLE, DONE: begin
                    if (w_arranque) begin
                        r_a      <= '0;
                        r_q      <= multiplicador;
                        r_q1     <= 1'b0;
                        r_m      <= {multiplicando[WIDTH-1], multiplicando};
                        r_cnt    <= CW'(WIDTH);
                        ocupado  <= 1'b1;
                        listo    <= 1'b0;
                        r_estado <= CALC;
                    end
                end
                CALC: begin
                    r_a   <= w_a;
                    r_q   <= w_q;
                    r_q1  <= w_q1;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        producto <= w_prod;
                        signo    <= w_prod[2*WIDTH-1];
                        magnitud <= w_mag;
                        ocupado  <= 1'b0;
                        listo    <= 1'b1;
                        r_estado <= DONE;
                    end
                end
                default: r_estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplicador.sv
// Directed-vector bench for booth_multiplicador with a result scoreboard.
module tb_booth_multiplicador;
    import booth_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pb;
    logic [7:0]  q_in;
    logic [7:0]  m_in;
    logic [15:0] producto;
    logic [15:0] magnitud;
    logic        signo;
    logic        ocupado;
    logic        listo;
    logic [1:0]  estado;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    // Entry layout: {signo, magnitud, producto}.
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;
    logic        listo_prev = 1'b0;

    always #5 clk = ~clk;

    booth_multiplicador #(.WIDTH(8)) dut (
        .Clk_100M     (clk),
        .reset        (rst),
        .pb_salida    (pb),
        .multiplicador(q_in),
        .multiplicando(m_in),
        .producto     (producto),
        .signo        (signo),
        .magnitud     (magnitud),
        .ocupado      (ocupado),
        .listo        (listo),
        .o_estado_dbg (estado)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of listo is one completed product.
    always @(negedge clk) begin
        if (listo && !listo_prev) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0h required=none", producto);
            end else begin
                exp_e = exp_q.pop_front();
                check("producto", 32'(producto), 32'(exp_e[15:0]));
                check("magnitud", 32'(magnitud), 32'(exp_e[31:16]));
                check("signo", 32'(signo), 32'(exp_e[32]));
            end
        end
        listo_prev = listo;
    end

    task automatic run_op(input logic [7:0] q, input logic [7:0] m,
                          input logic [15:0] p, input logic s, input logic [15:0] mag);
        q_in = q;
        m_in = m;
        exp_q.push_back({s, mag, p});
        pb = 1'b1;
        tick(1);
        check("estado_calc", 32'(estado), 32'(CALC));
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick(1);
            check("ocupado_calc", 32'(ocupado), 32'd1);
        end
        tick(1);
        check("listo_k9", 32'(listo), 32'd1);
        check("ocupado_k9", 32'(ocupado), 32'd0);
        pb = 1'b0;
        tick(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_producto"}, 32'(producto), 32'd0);
        check({tag, "_magnitud"}, 32'(magnitud), 32'd0);
        check({tag, "_signo"}, 32'(signo), 32'd0);
        check({tag, "_ocupado"}, 32'(ocupado), 32'd0);
        check({tag, "_listo"}, 32'(listo), 32'd0);
        check({tag, "_estado"}, 32'(estado), 32'(IDLE));
    endtask

    int d0;

    initial begin
        rst  = 1'b1;
        pb   = 1'b0;
        q_in = 8'h00;
        m_in = 8'h00;
        tick(3);
        check_reset_outputs("rst0");
        rst = 1'b0;
        tick(2);

        run_op(8'h03, 8'h05, 16'h000F, 1'b0, 16'h000F);
        run_op(8'hF9, 8'h06, 16'hFFD6, 1'b1, 16'h002A);
        run_op(8'h80, 8'h80, 16'h4000, 1'b0, 16'h4000);
        run_op(8'h7F, 8'h80, 16'hC080, 1'b1, 16'h3F80);

        // Operands change and the button re-presses while CALC runs.
        q_in = 8'h03;
        m_in = 8'h05;
        exp_q.push_back({1'b0, 16'h000F, 16'h000F});
        pb = 1'b1;
        tick(3);
        q_in = 8'h7F;
        m_in = 8'h7F;
        tick(1);
        pb = 1'b0;
        tick(1);
        pb = 1'b1;
        tick(3);
        check("chg_ocupado_k8", 32'(ocupado), 32'd1);
        d0 = n_done;
        tick(1);
        check("chg_listo_k9", 32'(listo), 32'd1);
        tick(15);
        check("chg_one_done", 32'(n_done - d0), 32'd1);
        check("chg_no_restart", 32'(ocupado), 32'd0);
        pb = 1'b0;
        tick(1);

        // Held button: a single completion over 1000 cycles.
        q_in = 8'h05;
        m_in = 8'hFD;
        exp_q.push_back({1'b1, 16'h000F, 16'hFFF1});
        d0 = n_done;
        pb = 1'b1;
        tick(1000);
        check("held_one_done", 32'(n_done - d0), 32'd1);
        check("held_listo", 32'(listo), 32'd1);
        pb = 1'b0;
        tick(3);
        q_in = 8'hF6;
        m_in = 8'hF6;
        exp_q.push_back({1'b0, 16'h0064, 16'h0064});
        pb = 1'b1;
        tick(1);
        check("restart_listo_drop", 32'(listo), 32'd0);
        check("restart_old_prod", 32'(producto), 32'h0000FFF1);
        tick(8);
        check("restart_listo_k9", 32'(listo), 32'd1);
        pb = 1'b0;
        tick(1);

        // Reset mid-CALC with the button still held through release.
        q_in = 8'h03;
        m_in = 8'h05;
        pb = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick(2);
        rst = 1'b0;
        tick(20);
        check_reset_outputs("rst_held");
        pb = 1'b0;
        tick(1);
        run_op(8'h02, 8'hFD, 16'hFFFA, 1'b1, 16'h0006);

        tick(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
